buyruk_kuyrugu: RTL

Instruction queue between the front-end fetch stage (`on_taraf`) and the decode stage (GC). It captures each instruction beat from the front end, buffers up to DERINLIK instructions with their PCs, and presents them to decode through a valid/ready handshake. It also turns decode/branch redirects into a single front-end fetch request (`bb_buy_istek`) and flushes all stale instructions.

---
 rtl/buyruk_kuyrugu.sv | 98 +++++++++
 1 files changed

// File: rtl/buyruk_kuyrugu.sv
// Instruction queue between the fetch front end and decode: buffers fetched
// words with their PCs and turns downstream redirects into one fetch request.
module buyruk_kuyrugu #(
  parameter int DERINLIK     = 4,
  parameter int BUYRUK_BIT   = 32,
  parameter int BB_ADRES_BIT = 32
) (
  input  logic                         clk_g,
  input  logic                         rst_g,
  input  logic                         bb_buy_gecerli_g,
  input  logic [BUYRUK_BIT-1:0]        bb_buy_g,
  input  logic [BB_ADRES_BIT-1:0]      bb_buy_ps_g,
  output logic                         gc_hazir_c,
  output logic                         bb_buy_istek_c,
  output logic [BB_ADRES_BIT-1:0]      bb_buy_istek_adres_c,
  output logic                         cz_buy_gecerli_c,
  output logic [BUYRUK_BIT-1:0]        cz_buy_c,
  output logic [BB_ADRES_BIT-1:0]      cz_buy_ps_c,
  input  logic                         cz_hazir_g,
  input  logic                         gc_yonlendir_g,
  input  logic [BB_ADRES_BIT-1:0]      gc_yonlendir_adres_g,
  output logic [$clog2(DERINLIK):0]    kuyruk_doluluk_c
);

  localparam int PW      = $clog2(DERINLIK);
  localparam int CW      = PW + 1;
  localparam int DOLU_I  = DERINLIK;
  localparam int SINIR_I = DERINLIK - 2;
  localparam logic [CW-1:0] DOLU  = CW'(DOLU_I);
  localparam logic [CW-1:0] SINIR = CW'(SINIR_I);

  logic [BUYRUK_BIT-1:0]   r_buyruk_mem [DERINLIK];
  logic [BB_ADRES_BIT-1:0] r_ps_mem     [DERINLIK];
  logic [PW-1:0]           r_oku;
  logic [PW-1:0]           r_yaz;
  logic [CW-1:0]           r_doluluk;
  logic                    r_hazir_q;
  logic                    r_istek_bekliyor;
  logic [BB_ADRES_BIT-1:0] r_adres;

  logic w_yer;
  logic w_push;
  logic w_pop;

  // Ready leaves room for the beat already in flight; a repeated word is only
  // a new beat if ready was high in the previous cycle.
  always_comb begin
    w_yer  = (r_doluluk <= SINIR);
    w_push = bb_buy_gecerli_g && r_hazir_q && !r_istek_bekliyor &&
             !gc_yonlendir_g && (r_doluluk != DOLU);
    w_pop  = (r_doluluk != '0) && cz_hazir_g;
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_oku            <= '0;
      r_yaz            <= '0;
      r_doluluk        <= '0;
      r_hazir_q        <= 1'b0;
      r_istek_bekliyor <= 1'b0;
      r_adres          <= '0;
    end else begin
      r_hazir_q <= gc_hazir_c;
      if (gc_yonlendir_g) begin
        r_oku            <= '0;
        r_yaz            <= '0;
        r_doluluk        <= '0;
        r_istek_bekliyor <= 1'b1;
        r_adres          <= gc_yonlendir_adres_g;
      end else begin
        if (w_push) r_yaz <= r_yaz + PW'(1);
        if (w_pop)  r_oku <= r_oku + PW'(1);
        if (w_push && !w_pop)
          r_doluluk <= r_doluluk + CW'(1);
        else if (!w_push && w_pop)
          r_doluluk <= r_doluluk - CW'(1);
        // The front end takes the request on raw space, ignoring the mask.
        if (r_istek_bekliyor && w_yer) r_istek_bekliyor <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_g) begin
    if (w_push) begin
      r_buyruk_mem[r_yaz] <= bb_buy_g;
      r_ps_mem[r_yaz]     <= bb_buy_ps_g;
    end
  end

  assign gc_hazir_c           = w_yer && !r_istek_bekliyor;
  assign bb_buy_istek_c       = r_istek_bekliyor;
  assign bb_buy_istek_adres_c = r_adres;
  assign cz_buy_gecerli_c     = (r_doluluk != '0);
  assign cz_buy_c             = r_buyruk_mem[r_oku];
  assign cz_buy_ps_c          = r_ps_mem[r_oku];
  assign kuyruk_doluluk_c     = r_doluluk;

endmodule
